// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out feeder with a one-word holding register.
// Words arrive over valid/ready and leave one bit per clock on q, back to back.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             q,
  output logic             q_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shift;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;
  logic             last_bit;
  logic             shifting;
  logic             out_bit;

  assign accept   = data_valid && data_ready;
  assign shifting = (state == S_SHIFT);
  assign last_bit = (cnt == CNT_LAST);

  // Move the next bit toward whichever end drives q.
  always_comb begin
    sreg_shift = sreg;
    if (LSB_FIRST) begin
      sreg_shift = {1'b0, sreg[WIDTH-1:1]};
    end else begin
      sreg_shift = {sreg[WIDTH-2:0], 1'b0};
    end
  end

  // Pick the live bit from the output end of the shifter.
  always_comb begin
    out_bit = 1'b0;
    if (LSB_FIRST) begin
      out_bit = sreg[0];
    end else begin
      out_bit = sreg[WIDTH-1];
    end
  end

  // Shifter, bit counter, holding register and state sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            sreg  <= data_in;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            sreg <= sreg_shift;
            cnt  <= cnt + CNT_ONE;
            if (accept) begin
              hold      <= data_in;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // Held word takes over with no idle cycle; ready is low here.
            sreg      <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (accept) begin
            sreg <= data_in;
            cnt  <= '0;
          end else begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and serial-side status, all from registered state.
  always_comb begin
    data_ready  = !hold_full;
    q_valid     = shifting;
    q           = shifting ? out_bit : IDLE_BIT;
    frame_start = shifting && (cnt == '0);
    busy        = shifting || hold_full;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of bit_serializer (8-bit MSB-first
// and 4-bit LSB-first instances) against hand-computed bit streams.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       q;
  logic       q_valid;
  logic       frame_start;
  logic       busy;

  logic [3:0] d4_in;
  logic       d4_valid;
  logic       d4_ready;
  logic       q4;
  logic       q4_valid;
  logic       f4_start;
  logic       busy4;

  int total;
  int bad;

  bit_serializer #(
    .WIDTH(8),
    .LSB_FIRST(1'b0),
    .IDLE_BIT(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .q(q),
    .q_valid(q_valid),
    .frame_start(frame_start),
    .busy(busy)
  );

  bit_serializer #(
    .WIDTH(4),
    .LSB_FIRST(1'b1),
    .IDLE_BIT(1'b0)
  ) dut4 (
    .clk(clk),
    .reset(reset),
    .data_in(d4_in),
    .data_valid(d4_valid),
    .data_ready(d4_ready),
    .q(q4),
    .q_valid(q4_valid),
    .frame_start(f4_start),
    .busy(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".q"}, 32'(q), 32'd0);
    chk({tag, ".q_valid"}, 32'(q_valid), 32'd0);
    chk({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".data_ready"}, 32'(data_ready), 32'd1);
  endtask

  // One isolated word: accept, eight MSB-first bits, then idle.
  task automatic run_word(input string tag, input logic [7:0] w);
    data_in    = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.q%0d", tag, i), 32'(q), 32'(w[7-i]));
      chk($sformatf("%s.v%0d", tag, i), 32'(q_valid), 32'd1);
      chk($sformatf("%s.fs%0d", tag, i), 32'(frame_start),
          (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
      tick();
    end
    chk_idle({tag, ".end"});
  endtask

  logic [7:0] words [3];
  logic       prev_q;
  logic       prev_v;
  logic       det;
  logic [3:0] w4;

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    d4_in      = 4'h0;
    d4_valid   = 1'b0;

    // Reset asserted between edges must act immediately.
    #2 reset = 1'b1;
    #1;
    chk_idle("rst_async");
    chk("rst_async.q4_valid", 32'(q4_valid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("rst_hold%0d", i));
    end

    // Single word, MSB first.
    run_word("single", 8'b1011_0010);

    // Back-to-back A5, 3C then a back-pressured 96: 24 gapless bits.
    words[0]   = 8'hA5;
    words[1]   = 8'h3C;
    words[2]   = 8'h96;
    data_in    = words[0];
    data_valid = 1'b1;
    tick();
    data_in = words[1];
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("b2b.q%0d", c), 32'(q),
          32'(words[c/8][7-(c%8)]));
      chk($sformatf("b2b.v%0d", c), 32'(q_valid), 32'd1);
      chk($sformatf("b2b.fs%0d", c), 32'(frame_start),
          ((c % 8) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b.rdy%0d", c), 32'(data_ready),
          (((c % 8) == 0) || (c >= 16)) ? 32'd1 : 32'd0);
      chk($sformatf("b2b.busy%0d", c), 32'(busy), 32'd1);
      tick();
      if (c == 0) data_in = words[2];
      if (c == 8) begin
        data_valid = 1'b0;
        data_in    = 8'h00;
      end
    end
    chk_idle("b2b.end");

    // Reset mid-word with a second word sitting in hold.
    data_in    = 8'hFF;
    data_valid = 1'b1;
    tick();
    data_in = 8'h0F;
    tick();
    data_valid = 1'b0;
    data_in    = 8'h00;
    chk("midrst.held", 32'(data_ready), 32'd0);
    tick();
    tick();
    chk("midrst.bit3_q", 32'(q), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_idle("midrst.now");
    tick();
    reset = 1'b0;
    tick();
    chk_idle("midrst.after");
    run_word("post_rst", 8'h5A);

    // 4-bit LSB-first: 0011 -> 1,1,0,0; a "11" detector fires on bit 1.
    w4       = 4'b0011;
    d4_in    = w4;
    d4_valid = 1'b1;
    tick();
    d4_valid = 1'b0;
    prev_q   = 1'b0;
    prev_v   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lsb4.q%0d", i), 32'(q4), 32'(w4[i]));
      chk($sformatf("lsb4.v%0d", i), 32'(q4_valid), 32'd1);
      chk($sformatf("lsb4.fs%0d", i), 32'(f4_start),
          (i == 0) ? 32'd1 : 32'd0);
      det = q4_valid && q4 && prev_v && prev_q;
      chk($sformatf("lsb4.det%0d", i), 32'(det),
          (i == 1) ? 32'd1 : 32'd0);
      prev_q = q4;
      prev_v = q4_valid;
      tick();
    end
    chk("lsb4.end_v", 32'(q4_valid), 32'd0);
    chk("lsb4.end_q", 32'(q4), 32'd0);
    chk("lsb4.end_busy", 32'(busy4), 32'd0);
    chk("lsb4.end_rdy", 32'(d4_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the serial sequence-detector FSM. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `q`, with `q_valid` marking live bits. A one-word holding register lets the producer queue the next word, so consecutive words go out with no idle cycles between them.

## Interface

Parameters:
- `WIDTH`, default 8: bits per word, must be 2 or more.
- `LSB_FIRST`, default 0: 0 sends the MSB first, 1 sends the LSB first.
- `IDLE_BIT`, default 1'b0: value driven on `q` when no bit is live.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `data_in`, input, WIDTH: parallel word from the producer.
- `data_valid`, input, 1: producer has a word on `data_in`.
- `data_ready`, output, 1: block can accept a word this cycle.
- `q`, output, 1: serial bit; connects to the detector's `q` input.
- `q_valid`, output, 1: `q` carries a live bit.
- `frame_start`, output, 1: high during the first bit of each word.
- `busy`, output, 1: shifter active or holding register full.

## Operation

- **Storage:**
  - Shift register `sreg` (WIDTH bits).
  - Bit counter `cnt`, range 0..WIDTH-1.
  - Holding register `hold` (WIDTH bits) with flag `hold_full`.
  - Two-state FSM: IDLE and SHIFT.
- **Handshake:**
  - A word is accepted on a rising edge where `data_valid && data_ready`.
  - `data_ready = !hold_full`, combinational from the registered flag.
  - The producer keeps `data_in` stable while `data_valid=1` and `data_ready=0`.
  - `data_in` is ignored when no accept occurs.
- **IDLE:**
  - On accept: load `sreg <= data_in`, set `cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:**
  - While `cnt < WIDTH-1`, each edge shifts `sreg` toward the output end and increments `cnt`.
  - An accept in this case writes `hold` and sets `hold_full`.
- **Last bit (`cnt == WIDTH-1`), at the edge:**
  - If `hold_full`: `sreg <= hold`, clear `hold_full`, `cnt <= 0`, stay in SHIFT. No accept is possible this cycle because `data_ready=0`.
  - Else if accept: `sreg <= data_in`, `cnt <= 0`, stay in SHIFT. This gives a gapless stream.
  - Else: go to IDLE.
- **Outputs:**
  - `q` = `sreg[WIDTH-1]` when `LSB_FIRST=0`, `sreg[0]` when `LSB_FIRST=1`. In IDLE, `q = IDLE_BIT`.
  - `q_valid = (state == SHIFT)`.
  - `frame_start = (state == SHIFT) && (cnt == 0)`.
  - `busy = (state == SHIFT) || hold_full`.
- **Reset:**
  - Forces IDLE, `cnt=0`, `hold_full=0`, `sreg=0`.
  - Output values during and after reset: `q=IDLE_BIT`, `q_valid=0`, `frame_start=0`, `busy=0`, `data_ready=1`.
  - Asserting reset mid-word discards the partial word and any held word without finishing them.
  - A handshake that coincides with reset is lost.

## Timing

- **Latency:** a word accepted at edge N puts its first bit on `q` in the cycle after edge N, and its last bit in the cycle after edge N+WIDTH-1.
- **Throughput:** one bit per clock. A new word can be consumed every WIDTH cycles.
- **Gapless output:** `q_valid` stays high continuously as long as the next word is accepted or held by each last-bit edge.
- **`data_ready` low:** drops the cycle after `hold` fills and returns high the cycle after `hold` drains into `sreg`.
- **Held words:** a word accepted into `hold` during bit 0 of the current word waits WIDTH-1 edges before shifting.
- **Downstream sampling:** the detector samples `q` on the same `clk` edge. Each bit is stable for exactly one full cycle.

## Test plan

1. **Reset values:** assert `reset` asynchronously between edges. Required: outputs go immediately to `q=0`, `q_valid=0`, `frame_start=0`, `busy=0`, `data_ready=1`. Release `reset` and check they hold with no stimulus.
2. **Single word, MSB first:** accept `8'b10110010`. Required:
   - `q` = 1,0,1,1,0,0,1,0 over the 8 cycles after the accept edge.
   - `frame_start` high on the first of those cycles only.
   - `q_valid` high for exactly 8 cycles, then `q=0` and `q_valid=0`.
3. **Back-to-back words:** hold `data_valid=1` with `8'hA5` then `8'h3C`. Required:
   - 16 consecutive `q_valid` cycles carrying 10100101 then 00111100.
   - `data_ready=0` while `8'h3C` sits in `hold`.
   - `frame_start` pulses at bit 0 and bit 8.
4. **Backpressure:** keep `data_valid=1` with a third word while `hold_full`. Required: no accept until `data_ready` returns, and the third word follows the second with no gap and no duplication.
5. **Reset mid-word:** assert `reset` after 3 bits of `8'hFF`. Required: `q_valid` drops immediately, the word is never completed, and a word accepted after release starts cleanly at bit 0.
6. **LSB_FIRST=1, WIDTH=4:** accept `4'b0011`. Required: `q` = 1,1,0,0. Also drive `q` into the detector FSM and check its output against the expected detection cycles.
